core_reg_read_arbiter: RTL and testbench
========================================

Name: core_reg_read_arbiter

Overview:
- Shares the single registered read port of the GP register file among NUM_REQ requesters (e.g. decode operand fetch, debug/trace port, exception unit).
- Requesters ask for one or two registers per transaction (operand pair). The arbiter sequences the port reads and routes each result back, tagged with requester and slot.
- Sits between the requesters and the register file's read address/read data pins; the file's write side and forwarding stay untouched.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 is highest priority at reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request; held with its operands until req_ready.
- req_pair  in  NUM_REQ  per-requester: 1 = read reg_a then reg_b; 0 = reg_a only.
- req_reg_a  in  NUM_REQ x reg_num  first register number.
- req_reg_b  in  NUM_REQ x reg_num  second register number; ignored when req_pair=0.
- req_ready  out  NUM_REQ  one-hot grant pulse; the request is accepted in that cycle.
- file_rd_r  out  reg_num  read address to register file.
- file_rd_value  in  word  register file read data; valid one cycle after the address.
- rsp_valid  out  NUM_REQ  one-hot: rsp_value belongs to this requester this cycle.
- rsp_slot  out  1  0 = reg_a result, 1 = reg_b result.
- rsp_value  out  word  combinational pass-through of file_rd_value.
- busy  out  1  high while a pair's second read is pending issue.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=ARB; rr_ptr=0; req_ready=0; rsp_valid=0; rsp_slot=0; file_rd_r=0; busy=0.
  - Any in-flight read or response is dropped; no rsp_valid in the cycle after reset.
- State ARB:
  - If any req_valid, select a winner by round-robin, starting the search at rr_ptr.
  - For the winner, drive req_ready[w]=1 (combinational, same cycle) and file_rd_r=req_reg_a[w].
  - Set rr_ptr <= (w+1) mod NUM_REQ.
  - If req_pair[w]=1: capture req_reg_b[w] and w, then go to state SECOND.
  - If no req_valid: hold file_rd_r at its last value and issue no response.
- State SECOND:
  - file_rd_r = captured reg_b; busy=1; all req_ready=0.
  - Go to ARB next cycle; arbitration of the next request resumes there (one arbitration every cycle except SECOND).
- Response pipeline:
  - An issue in cycle T produces rsp_valid[w]=1 in cycle T+1, with rsp_slot registered from the issue (0 for reg_a, 1 for reg_b).
  - Throughput: single reads back-to-back at 1 per cycle; a pair occupies the port 2 cycles; results at T+1 and T+2.
- A requester must not change req_* while req_valid=1 and req_ready=0. Dropping req_valid before grant is legal (the request is withdrawn).
- Write/read collision ordering comes from the file's forwarding; the arbiter adds no extra latency or stall.
- Reset during SECOND: the captured reg_b read is never issued and no slot-1 response appears.
- req_pair with reg_a==reg_b is legal: two identical reads.

Optional Feature:
- CORE_REG_ARB_FIXED_PRIO_EN
  - Defined: fixed priority (lowest index wins); rr_ptr is removed.
  - Undefined: round-robin as above.

Decomposition:
- Shared package (uarch.sv): reuse word and reg_num; `NUM_GPREGS bounds the register numbers. Add arb_state_t enum {ARB, SECOND} and a req_idx width constant $clog2(NUM_REQ).
- One natural sub-module: core_rr_picker (rotating-priority one-hot picker, with a fixed-priority variant under the macro).

Test Plan:
- Reset check: after rst held 2 cycles → all outputs 0, state ARB, and no rsp_valid in the first cycle after rst falls.
- Single read: req0 valid, pair=0, reg_a=5, file returns 0xDEAD_BEEF → req_ready[0] at T, file_rd_r=5 at T; at T+1 rsp_valid=001, slot 0, value 0xDEAD_BEEF.
- Pair read: req1 pair=1, reg_a=3, reg_b=7 → file_rd_r 3 at T and 7 at T+1; busy=1 at T+1; rsp_valid=010 at T+1 (slot 0) and T+2 (slot 1).
- Round-robin fairness: all 3 requesters continuously valid with single reads → grants 0,1,2,0,1,2; with the macro defined → grants always 0.
- Contention during SECOND: req0 pair granted at T while req2 is waiting → req2 granted at T+2, not T+1; its rsp_valid appears at T+3.
- Reset mid-pair: rst asserted at T+1 after a pair grant at T → no slot-1 response; after reset, rr_ptr=0 and req0 wins first.

Source files
------------

// File: rtl/core_reg_read_arbiter_pkg.sv
// Shared types for the GP register-file read-port arbiter.
// CORE_REG_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package core_reg_read_arbiter_pkg;

    localparam int NUM_GPREGS = 32;
    localparam int WORD_W     = 32;
    localparam int REG_NUM_W  = $clog2(NUM_GPREGS);

    typedef logic [WORD_W-1:0]    word;
    typedef logic [REG_NUM_W-1:0] reg_num;

    typedef enum logic {
        ARB    = 1'b0,
        SECOND = 1'b1
    } arb_state_t;

    // Requester index width; a single requester still needs one bit.
    function automatic int req_idx_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/core_reg_read_arbiter_rr_picker.sv
// One-hot picker: rotating priority starting at ptr, or lowest-index-wins
// when CORE_REG_ARB_FIXED_PRIO_EN is defined (ptr is then ignored).
module core_rr_picker
    import core_reg_read_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = req_idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

`ifdef CORE_REG_ARB_FIXED_PRIO_EN
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
                any       = 1'b1;
            end
        end
    end
`else
    always_comb begin
        int k;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        k         = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!any && req[k]) begin
                grant[k]  = 1'b1;
                grant_idx = IW'(k);
                any       = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/core_reg_read_arbiter.sv
// Shares the register file's single read port among NUM_REQ requesters.
// Build option: CORE_REG_ARB_FIXED_PRIO_EN (fixed priority, no rr pointer).
module core_reg_read_arbiter
    import core_reg_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_pair,
    input  reg_num [NUM_REQ-1:0] req_reg_a,
    input  reg_num [NUM_REQ-1:0] req_reg_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output reg_num               file_rd_r,
    input  word                  file_rd_value,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic                 rsp_slot,
    output word                  rsp_value,
    output logic                 busy,
    output arb_state_t           dbg_state
);

    localparam int IW = req_idx_w(NUM_REQ);

    // Handshake: req_ready[w] is a combinational same-cycle accept of a held
    // req_valid[w]; responses are unconditional one-cycle pulses (no backpressure).

    arb_state_t           state_q, state_d;
    reg_num               rd_r_q, rd_r_d;
    reg_num               reg_b_q, reg_b_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 rsp_slot_q, rsp_slot_d;
    logic [IW-1:0]        pick_ptr;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;

`ifndef CORE_REG_ARB_FIXED_PRIO_EN
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    assign pick_ptr = rr_ptr_q;
`else
    assign pick_ptr = '0;
`endif

    core_rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req       (req_valid),
        .ptr       (pick_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // No grant or issue while rst is high: whatever would be accepted is dropped.
    always_comb begin
        state_d     = state_q;
        rd_r_d      = rd_r_q;
        reg_b_d     = reg_b_q;
        owner_d     = owner_q;
        rsp_valid_d = '0;
        rsp_slot_d  = 1'b0;
        req_ready   = '0;
`ifndef CORE_REG_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            ARB: begin
                if (pick_any && !rst) begin
                    req_ready   = pick_grant;
                    rd_r_d      = req_reg_a[pick_idx];
                    rsp_valid_d = pick_grant;
`ifndef CORE_REG_ARB_FIXED_PRIO_EN
                    rr_ptr_d    = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
`endif
                    if (req_pair[pick_idx]) begin
                        reg_b_d = req_reg_b[pick_idx];
                        owner_d = pick_idx;
                        state_d = SECOND;
                    end
                end
            end
            SECOND: begin
                state_d = ARB;
                if (!rst) begin
                    rd_r_d               = reg_b_q;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_slot_d           = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            rd_r_q      <= '0;
            reg_b_q     <= '0;
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_slot_q  <= 1'b0;
`ifndef CORE_REG_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_r_q      <= rd_r_d;
            reg_b_q     <= reg_b_d;
            owner_q     <= owner_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_slot_q  <= rsp_slot_d;
`ifndef CORE_REG_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    // rd_r_d already holds the address being presented this cycle.
    assign file_rd_r = rd_r_d;
    assign rsp_valid = rsp_valid_q;
    assign rsp_slot  = rsp_slot_q;
    assign rsp_value = file_rd_value;
    assign busy      = (state_q == SECOND);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_core_reg_read_arbiter.sv
// Randomised bench for core_reg_read_arbiter against a transaction-level model.
module tb_core_reg_read_arbiter;
    import core_reg_read_arbiter_pkg::*;

    localparam int N     = 3;
    localparam int ENT_W = 1 + 3 + 1 + REG_NUM_W;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_pair;
    reg_num [N-1:0] req_reg_a;
    reg_num [N-1:0] req_reg_b;
    logic [N-1:0]   req_ready;
    reg_num         file_rd_r;
    word            file_rd_value;
    logic [N-1:0]   rsp_valid;
    logic           rsp_slot;
    word            rsp_value;
    logic           busy;
    arb_state_t     dbg_state;

    word mem [NUM_GPREGS];

    // clock / reset / register-file model
    always #5 clk = ~clk;
    always @(posedge clk) file_rd_value <= mem[file_rd_r];

    core_reg_read_arbiter #(.NUM_REQ(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_pair      (req_pair),
        .req_reg_a     (req_reg_a),
        .req_reg_b     (req_reg_b),
        .req_ready     (req_ready),
        .file_rd_r     (file_rd_r),
        .file_rd_value (file_rd_value),
        .rsp_valid     (rsp_valid),
        .rsp_slot      (rsp_slot),
        .rsp_value     (rsp_value),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // scoreboard: {valid, owner[2:0], slot, reg} of the response due next cycle
    logic [ENT_W-1:0] exp_q[$];
    int     m_ptr;
    int     m_pend;
    int     m_pend_owner;
    reg_num m_pend_reg;
    reg_num m_last_addr;
    int     m_grant;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_step();
        logic [ENT_W-1:0] ent;
        logic [N-1:0]     exp_ready;
        logic [N-1:0]     exp_rsp;
        reg_num           exp_addr;
        int               w;
        int               j;
        m_grant = -1;
        if (rst) begin
            m_pend      = 0;
            m_ptr       = 0;
            m_last_addr = '0;
            exp_q.delete();
            return;
        end
        ent     = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        exp_rsp = '0;
        if (ent[ENT_W-1]) exp_rsp[ent[ENT_W-2 -: 3]] = 1'b1;
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        if (ent[ENT_W-1]) begin
            check("rsp_slot", 64'(rsp_slot), 64'(ent[REG_NUM_W]));
            check("rsp_value", 64'(rsp_value), 64'(mem[ent[REG_NUM_W-1:0]]));
        end
        check("busy", 64'(busy), 64'(m_pend));
        check("dbg_state", 64'(dbg_state), (m_pend != 0) ? 64'(SECOND) : 64'(ARB));
        exp_ready = '0;
        exp_addr  = m_last_addr;
        if (m_pend != 0) begin
            exp_addr = m_pend_reg;
            exp_q.push_back({1'b1, 3'(m_pend_owner), 1'b1, m_pend_reg});
            m_pend = 0;
        end else begin
            w = -1;
            for (int i = 0; i < N; i++) begin
                j = (m_ptr + i) % N;
                if (w < 0 && req_valid[j]) w = j;
            end
            if (w >= 0) begin
                exp_ready[w] = 1'b1;
                exp_addr     = req_reg_a[w];
                exp_q.push_back({1'b1, 3'(w), 1'b0, req_reg_a[w]});
`ifdef CORE_REG_ARB_FIXED_PRIO_EN
                m_ptr = 0;
`else
                m_ptr = (w + 1) % N;
`endif
                if (req_pair[w]) begin
                    m_pend       = 1;
                    m_pend_owner = w;
                    m_pend_reg   = req_reg_b[w];
                end
                m_grant = w;
            end
        end
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("file_rd_r", 64'(file_rd_r), 64'(exp_addr));
        m_last_addr = exp_addr;
    endtask

    // driver tasks
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        settle();
        advance();
        rst = 1'b0;
    endtask

    task automatic new_req(input int i);
        req_pair[i]  = 1'($urandom_range(0, 1));
        req_reg_a[i] = reg_num'($urandom_range(0, NUM_GPREGS - 1));
        req_reg_b[i] = ($urandom_range(0, 3) == 0) ? req_reg_a[i]
                                                   : reg_num'($urandom_range(0, NUM_GPREGS - 1));
    endtask

    task automatic rand_stim();
        for (int i = 0; i < N; i++) begin
            if (m_grant == i || (!req_valid[i] && $urandom_range(0, 2) == 0)) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                new_req(i);
            end else if (req_valid[i] && $urandom_range(0, 7) == 0) begin
                req_valid[i] = 1'b0;
            end
        end
        rst = ($urandom_range(0, 63) == 0);
    endtask

    initial begin
        logic [N-1:0] exp_g;
        rst       = 1'b1;
        req_valid = '0;
        req_pair  = '0;
        req_reg_a = '0;
        req_reg_b = '0;
        m_ptr = 0; m_pend = 0; m_pend_owner = 0; m_pend_reg = '0; m_last_addr = '0; m_grant = -1;
        for (int i = 0; i < NUM_GPREGS; i++) mem[i] = $urandom;
        mem[5] = 32'hDEAD_BEEF;

        // reset held two edges
        @(posedge clk); #1;
        @(posedge clk); #1;
        settle();
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_slot", 64'(rsp_slot), 64'd0);
        check("rst_rd_r", 64'(file_rd_r), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ARB));
        advance();
        rst = 1'b0;

        // single read
        req_valid = 3'b001; req_pair = 3'b000; req_reg_a[0] = 5;
        settle();
        check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
        check("single_ready", 64'(req_ready), 64'b001);
        check("single_addr", 64'(file_rd_r), 64'd5);
        advance();
        req_valid = '0;
        settle();
        check("single_rsp_valid", 64'(rsp_valid), 64'b001);
        check("single_rsp_slot", 64'(rsp_slot), 64'd0);
        check("single_rsp_value", 64'(rsp_value), 64'hDEAD_BEEF);
        advance();

        // pair read
        req_valid = 3'b010; req_pair = 3'b010; req_reg_a[1] = 3; req_reg_b[1] = 7;
        settle();
        check("pair_ready", 64'(req_ready), 64'b010);
        check("pair_addr_a", 64'(file_rd_r), 64'd3);
        advance();
        req_valid = '0;
        settle();
        check("pair_addr_b", 64'(file_rd_r), 64'd7);
        check("pair_busy", 64'(busy), 64'd1);
        check("pair_rsp_a", 64'({rsp_valid, rsp_slot}), 64'b0100);
        advance();
        settle();
        check("pair_rsp_b", 64'({rsp_valid, rsp_slot}), 64'b0101);
        check("pair_rsp_b_value", 64'(rsp_value), 64'(mem[7]));
        advance();

        // fairness with everyone continuously valid
        do_reset();
        req_valid = 3'b111; req_pair = 3'b000;
        req_reg_a[0] = 1; req_reg_a[1] = 2; req_reg_a[2] = 4;
        for (int k = 0; k < 6; k++) begin
            settle();
`ifdef CORE_REG_ARB_FIXED_PRIO_EN
            exp_g = 3'b001;
`else
            exp_g = 3'(1 << (k % 3));
`endif
            check("fair_grant", 64'(req_ready), 64'(exp_g));
            advance();
        end
        req_valid = '0;
        settle(); advance();

        // contention while a pair occupies the port
        do_reset();
        req_valid = 3'b101; req_pair = 3'b001;
        req_reg_a[0] = 9; req_reg_b[0] = 10; req_reg_a[2] = 11;
        settle();
        check("cont_t0_ready", 64'(req_ready), 64'b001);
        advance();
        req_valid = 3'b100;
        settle();
        check("cont_t1_ready", 64'(req_ready), 64'b000);
        check("cont_t1_busy", 64'(busy), 64'd1);
        advance();
        settle();
        check("cont_t2_ready", 64'(req_ready), 64'b100);
        advance();
        req_valid = '0;
        settle();
        check("cont_t3_rsp", 64'({rsp_valid, rsp_slot}), 64'b1000);
        advance();

        // reset one cycle after a pair grant
        do_reset();
        req_valid = 3'b010; req_pair = 3'b010; req_reg_a[1] = 12; req_reg_b[1] = 13;
        settle();
        check("midpair_ready", 64'(req_ready), 64'b010);
        advance();
        req_valid = '0; rst = 1'b1;
        settle();
        check("midpair_rst_ready", 64'(req_ready), 64'd0);
        advance();
        rst = 1'b0; req_valid = 3'b111; req_pair = 3'b000;
        settle();
        check("midpair_no_slot1", 64'(rsp_valid), 64'd0);
        check("midpair_req0_first", 64'(req_ready), 64'b001);
        advance();
        req_valid = '0;
        settle(); advance();

        // randomized traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            settle();
            advance();
            rand_stim();
        end
        rst = 1'b0; req_valid = '0;
        settle(); advance();
        settle(); advance();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
